// File: rtl/uart_matrix_txfifo.sv
// Synchronous byte FIFO for one matrix TX port.
// The head byte is visible on dout (first-word fall-through), so the
// serializer can load it in the same cycle it pops.
// full/empty are registered flags derived from the registered level.
`ifndef UART_MATRIX_TXFIFO_SV
`define UART_MATRIX_TXFIFO_SV

module uart_matrix_txfifo #(
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in,
  input  logic                     cke,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_lvl = depth[aw:0];
  localparam logic [aw:0] one_lvl  = {{aw{1'b0}}, 1'b1};
  localparam logic [aw-1:0] one_ptr = {{(aw-1){1'b0}}, 1'b1};

  logic [7:0]    mem [depth];
  logic [aw-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [aw:0]   level_reg, level_next;
  logic          full_reg, empty_reg;
  logic          push, pop_ok;

  // A write is admitted only against the registered full flag, so a pop in
  // the same cycle never makes room for it.
  assign push   = cke & ~full_reg;
  assign pop_ok = pop & ~empty_reg;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next = level_reg;
    case ({push, pop_ok})
      2'b10:   level_next = level_reg + one_lvl;
      2'b01:   level_next = level_reg - one_lvl;
      default: level_next = level_reg;
    endcase
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in;
  end

  // Pointers, level and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + one_ptr;
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + one_ptr;
      level_reg <= level_next;
      full_reg  <= (level_next == full_lvl);
      empty_reg <= (level_next == '0);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign level = level_reg;
endmodule

`endif

// File: rtl/uart_matrix_txport.sv
// Downstream TX port of the UART matrix: byte FIFO plus 8N1 serializer.
// The line output is registered from the current FSM state, so it trails the
// state by one cycle; back-to-back frames are chained straight from STOP.
`ifndef UART_MATRIX_TXPORT_SV
`define UART_MATRIX_TXPORT_SV

module uart_matrix_txport #(
  parameter int depth = 16,
  parameter int div   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in,
  input  logic                    cke,
  output logic                    out,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  level,
  output logic                    overflow
);
  localparam int frame_bits = 10;
  localparam int data_last  = frame_bits - 3;
  localparam logic [2:0] bit_last = data_last[2:0];
  localparam int cw = $clog2(div) + 1;
  localparam int div_m1 = div - 1;
  localparam logic [cw-1:0] cnt_last = div_m1[cw-1:0];
  localparam logic [cw-1:0] cnt_one  = {{(cw-1){1'b0}}, 1'b1};

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_start = 2'd1;
  localparam logic [1:0] st_data  = 2'd2;
  localparam logic [1:0] st_stop  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = st_idle,
    START = st_start,
    DATA  = st_data,
    STOP  = st_stop
  } state_t;

  state_t        state_reg, state_next;
  logic [cw-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          out_reg, out_next;
  logic          overflow_reg;
  logic          pop;
  logic [7:0]    head;
  logic          bit_end;

  uart_matrix_txfifo #(.depth(depth)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .cke   (cke),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bit_end = (cnt_reg == cnt_last);

  // Serializer next-state, counters, FIFO pop and the line level for this state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    out_next   = 1'b1;
    case (state_reg)
      IDLE: begin
        out_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        out_next = 1'b0;
        if (bit_end) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      DATA: begin
        out_next = shift_reg[0];
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == bit_last) state_next = STOP;
          else                     bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      STOP: begin
        out_next = 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + cnt_one;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Serializer registers; reset aborts any frame and drives the line idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      out_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      out_reg   <= out_next;
    end
  end

  // Sticky flag for a write that arrived while the FIFO was full.
  always_ff @(posedge clk) begin
    if (reset)            overflow_reg <= 1'b0;
    else if (cke && full) overflow_reg <= 1'b1;
  end

  assign out      = out_reg;
  assign overflow = overflow_reg;
endmodule

`endif

// File: tb/tb_uart_matrix_txport.sv
// Randomized bench for uart_matrix_txport: two instances (slow baud with a
// small FIFO, and one cycle per bit with a larger FIFO) share the stimulus and
// are each compared every cycle against a frame-level reference model.

module tb_uart_matrix_txport;
  localparam int DP_A = 4;
  localparam int DV_A = 3;
  localparam int DP_B = 8;
  localparam int DV_B = 1;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cke = 1'b0;
  logic [7:0] din = 8'h00;

  logic       out_a, full_a, empty_a, ovf_a;
  logic [2:0] level_a;
  logic       out_b, full_b, empty_b, ovf_b;
  logic [3:0] level_b;

  uart_matrix_txport #(.depth(DP_A), .div(DV_A)) u_dut_a (
    .clk(clk), .reset(reset), .in(din), .cke(cke), .out(out_a),
    .full(full_a), .empty(empty_a), .level(level_a), .overflow(ovf_a)
  );

  uart_matrix_txport #(.depth(DP_B), .div(DV_B)) u_dut_b (
    .clk(clk), .reset(reset), .in(din), .cke(cke), .out(out_b),
    .full(full_b), .empty(empty_b), .level(level_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: FIFO as a circular list, current frame as a
  // 10-bit pattern plus the number of line cycles still to go.
  int         dv [2] = '{DV_A, DV_B};
  int         dp [2] = '{DP_A, DP_B};
  int         fmem [2][8];
  int         fhead [2];
  int         fcnt [2];
  int         rem [2];
  logic [9:0] frame [2];
  logic       m_ovf [2];
  logic       m_out [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the port as seen from outside: line level of the cycle
  // just ended, a new frame whenever the previous one has fully elapsed and a
  // byte was already queued, and writes judged against the pre-edge fill.
  task automatic model_step(input int k, input logic rst, input logic wr, input logic [7:0] d);
    int   n0;
    int   flen;
    logic cur;
    if (rst) begin
      fhead[k] = 0; fcnt[k] = 0; rem[k] = 0;
      m_ovf[k] = 1'b0; m_out[k] = 1'b1;
      return;
    end
    flen = 10 * dv[k];
    cur = 1'b1;
    if (rem[k] > 0) begin
      cur = frame[k][(flen - rem[k]) / dv[k]];
      rem[k]--;
    end
    n0 = fcnt[k];
    if (rem[k] == 0 && n0 > 0) begin
      frame[k] = {1'b1, fmem[k][fhead[k]][7:0], 1'b0};
      rem[k]   = flen;
      fhead[k] = (fhead[k] + 1) % dp[k];
      fcnt[k]--;
    end
    if (wr) begin
      if (n0 == dp[k]) m_ovf[k] = 1'b1;
      else begin
        fmem[k][(fhead[k] + fcnt[k]) % dp[k]] = int'(d);
        fcnt[k]++;
      end
    end
    m_out[k] = cur;
  endtask

  task automatic check_all();
    check_eq("a_out",   32'(out_a),   32'(m_out[0]));
    check_eq("a_level", 32'(level_a), fcnt[0]);
    check_eq("a_empty", 32'(empty_a), 32'(fcnt[0] == 0));
    check_eq("a_full",  32'(full_a),  32'(fcnt[0] == DP_A));
    check_eq("a_ovf",   32'(ovf_a),   32'(m_ovf[0]));
    check_eq("b_out",   32'(out_b),   32'(m_out[1]));
    check_eq("b_level", 32'(level_b), fcnt[1]);
    check_eq("b_empty", 32'(empty_b), 32'(fcnt[1] == 0));
    check_eq("b_full",  32'(full_b),  32'(fcnt[1] == DP_B));
    check_eq("b_ovf",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      int phase;
      int wr_pct;
      @(posedge clk);
      model_step(0, reset, cke, din);
      model_step(1, reset, cke, din);
      #1;
      check_all();
      // New inputs for the next edge: bursty, sparse and silent phases,
      // occasional mid-stream resets, and a quiet tail to drain all frames.
      phase = (i / 400) % 3;
      wr_pct = (phase == 0) ? 60 : (phase == 1) ? 6 : 1;
      if (i < 3)              reset = 1'b1;
      else if (i < NCYC - 400) reset = ($urandom_range(0, 599) == 0);
      else                    reset = 1'b0;
      cke = (i < NCYC - 400) && ($urandom_range(0, 99) < wr_pct);
      din = 8'($urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
